// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: RAW hazard detect, multiplier sequencing and redirect flush for a 3-stage control pipeline
module hazard_stall_ctrl #(
   parameter int unsigned MUL_LAT    = 4,
   parameter int unsigned WB_FORWARD = 1,
   parameter int unsigned R0_EXEMPT  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] id_inst,
   input  logic        id_valid,
   input  logic [15:0] ex_ctrl,
   input  logic [11:0] ex_regs,
   input  logic [15:0] wb_ctrl,
   input  logic [11:0] wb_regs,
   input  logic        branch_taken,
   output logic        pc_stall,
   output logic        ir_stall,
   output logic        bubble,
   output logic        flush,
   output logic        mul_start,
   output logic        mul_busy,
   output logic [15:0] stall_cnt,
   output logic        err
);
   typedef enum logic [1:0] {RUN, MUL_BUSY, FLUSH} state_t;
   localparam int CW = MUL_LAT > 2 ? $clog2(MUL_LAT) : 1;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0] op, rs, rt;
   logic use_rs, use_rt, hazard, redirect, busy;
   logic unused;
   assign op = id_inst[15:12];
   assign rs = id_inst[7:4];
   assign rt = id_inst[3:0];
   assign use_rs = op != 4'd11;
   assign use_rt = op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13, 4'd14, 4'd15};
   assign busy = state == MUL_BUSY;
   assign redirect = branch_taken || ex_ctrl[7:6] == 2'b10;
   assign unused = ^{id_inst[11:8], ex_ctrl[15:9], ex_ctrl[5:0], ex_regs[7:0], wb_ctrl[15:9], wb_ctrl[7:0], wb_regs[7:0]};
   function automatic logic hit(input logic [3:0] src);
      return (R0_EXEMPT == 0 || src != 4'd0) &&
             ((ex_ctrl[8] && src == ex_regs[11:8]) ||
              (WB_FORWARD == 0 && wb_ctrl[8] && src == wb_regs[11:8]));
   endfunction
   assign hazard = id_valid && ((use_rs && hit(rs)) || (use_rt && hit(rt)));
   // next state and stall/flush/start decode; busy ignores redirects, then redirect > hazard > mul issue
   always_comb begin
      state_n = RUN;
      cnt_n = cnt;
      pc_stall = 1'b0;
      ir_stall = 1'b0;
      bubble = 1'b0;
      flush = 1'b0;
      mul_start = 1'b0;
      if (busy) begin
         pc_stall = 1'b1;
         ir_stall = 1'b1;
         bubble = 1'b1;
         cnt_n = cnt - 1'b1;
         state_n = cnt == CW'(1) ? RUN : MUL_BUSY;
      end else if (redirect) begin
         flush = 1'b1;
         bubble = 1'b1;
      end else if (hazard) begin
         pc_stall = 1'b1;
         ir_stall = 1'b1;
         bubble = 1'b1;
      end else if (id_valid && op == 4'hF) begin
         mul_start = 1'b1;
         if (MUL_LAT > 1) begin
            state_n = MUL_BUSY;
            cnt_n = CW'(MUL_LAT - 1);
         end
      end
      if (!rst_n) begin
         pc_stall = 1'b0;
         ir_stall = 1'b0;
         bubble = 1'b0;
         flush = 1'b0;
         mul_start = 1'b0;
      end
   end
   // state, multiplier countdown and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt <= '0;
         mul_busy <= 1'b0;
         stall_cnt <= '0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         mul_busy <= state_n == MUL_BUSY;
         stall_cnt <= (pc_stall && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
         err <= err || (busy && redirect);
      end
   end
endmodule
